// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues the instruction SRAM
// request and offers the fetched instruction to ID. Handles redirect from ID,
// stall from the hazard unit, and holds data returned while ID is busy.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        block_if,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

  logic        to_fs_valid;
  logic        fs_valid;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic        rdata_live;   // SRAM data on the bus belongs to the IF instruction
  logic        cancel;
  logic        fs_handshake;
  logic        fs_allowin;
  logic [31:0] nextpc;

  // Control and next-PC selection: a final redirect beats everything,
  // including a hazard stall, so the redirect fetch never waits.
  always_comb begin
    cancel         = br_taken && !br_stall;
    fs_to_ds_valid = fs_valid && !cancel;
    fs_handshake   = fs_to_ds_valid && ds_allowin && !block_if;
    fs_allowin     = !fs_valid || fs_handshake || cancel;
    if (cancel)          nextpc = br_target;
    else if (pend_valid) nextpc = pend_target;
    else                 nextpc = fs_pc + 32'd4;
    inst_sram_en   = to_fs_valid && fs_allowin;
    inst_sram_addr = nextpc;
    fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
  end

  // Pre-IF becomes valid on the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) to_fs_valid <= 1'b0;
    else        to_fs_valid <= 1'b1;
  end

  // Fetch PC / IF valid / deferred redirect. A redirect that cannot issue
  // (pre-IF not yet valid) is remembered and consumed by the next fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else if (inst_sram_en) begin
      fs_valid    <= 1'b1;
      fs_pc       <= nextpc;
      pend_valid  <= 1'b0;
    end else if (cancel) begin
      fs_valid    <= 1'b0;
      pend_valid  <= 1'b1;
      pend_target <= br_target;
    end else if (fs_handshake) begin
      fs_valid    <= 1'b0;
    end
  end

  // SRAM data is only on the bus for one cycle; capture it if ID cannot
  // take it that cycle so fs_inst stays stable until the transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_live <= 1'b0;
      buf_valid  <= 1'b0;
      inst_buf   <= 32'h0;
    end else begin
      rdata_live <= inst_sram_en;
      if (fs_handshake || cancel) begin
        buf_valid <= 1'b0;
      end else if (fs_valid && rdata_live && !buf_valid) begin
        buf_valid <= 1'b1;
        inst_buf  <= inst_sram_rdata;
      end
    end
  end

endmodule
